// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data-bit count and frame-length helper.
// Intended for both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Cycles from the handshake edge to the edge that returns to IDLE.
    function automatic int frame_len(input int cpb, input int stop_bits, input bit parity);
        return (1 + DATA_BITS + int'(parity) + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-CLKS_PER_BIT counter with enable and clear; bit_done pulses on the
// last cycle of each bit period. Shared by the UART transmitter and receiver.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic clr,
    output logic bit_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
        end
    end

    assign bit_done = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, idle-high line. Define UART_TX_PARITY_EN to
// insert an even-parity bit between the data and stop bits (8E1/8E2).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [8:0] wr_opt_byte,
    output logic       wr_ready,
    output logic       line_out
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e state;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif

    assign wr_ready = (state == IDLE);

    // Timer is held at zero in IDLE so every frame starts on a fresh bit period.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (state != IDLE),
        .clr      (state == IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            line_out <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    line_out <= 1'b1;
                    if (wr_opt_byte[8]) begin
                        shift    <= wr_opt_byte[7:0];
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^wr_opt_byte[7:0];
`endif
                        state    <= START;
                        line_out <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        line_out <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            line_out <= par_bit;
`else
                            state    <= STOP;
                            line_out <= 1'b1;
`endif
                        end else begin
                            // line_out follows the bit that becomes shift[0]
                            bit_idx  <= bit_idx + 3'd1;
                            shift    <= {1'b0, shift[7:1]};
                            line_out <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        line_out <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    line_out <= 1'b1;
                    if (bit_done) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    line_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
